// File: rtl/reverb_bypass_xfade.sv
// Click-free dry/wet crossfade for the reverb bypass control.
// The gain ramps one step per accepted sample; the mix goes out through a single output register.
module reverb_bypass_xfade #(
    parameter int DATA_W    = 16,
    parameter int RAMP_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     fx_enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] dry_data,
    input  logic signed [DATA_W-1:0] wet_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [1:0]               xfade_state,
    output logic [RAMP_LOG2:0]       gain
);

    typedef enum logic [1:0] {
        ST_DRY       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_WET       = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } xfade_t;

    localparam int PW = DATA_W + RAMP_LOG2 + 2;
    localparam int SW = PW + 1;
    localparam int GW = RAMP_LOG2 + 1;
    localparam logic [GW-1:0] RAMP_G = {1'b1, {RAMP_LOG2{1'b0}}};

    logic                     sync1_reg;
    logic                     en_s_reg;
    xfade_t                   state_reg;
    logic [GW-1:0]            g_reg;
    logic [GW-1:0]            g_next;
    logic                     out_valid_reg;
    logic signed [DATA_W-1:0] out_data_reg;
    logic                     accept;

    logic [GW-1:0]            dry_coef;
    logic signed [PW-1:0]     dry_ext;
    logic signed [PW-1:0]     wet_ext;
    logic signed [PW-1:0]     dry_coef_ext;
    logic signed [PW-1:0]     wet_coef_ext;
    logic signed [PW-1:0]     dry_prod;
    logic signed [PW-1:0]     wet_prod;
    logic signed [SW-1:0]     mix_sum;
    logic signed [DATA_W-1:0] mix_out;
    logic                     unused_mix_bits;

    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;

    // Convex combination, so bits above DATA_W after the shift are pure sign extension.
    assign dry_coef     = RAMP_G - g_reg;
    assign dry_ext      = {{(PW-DATA_W){dry_data[DATA_W-1]}}, dry_data};
    assign wet_ext      = {{(PW-DATA_W){wet_data[DATA_W-1]}}, wet_data};
    assign dry_coef_ext = {{(PW-GW){1'b0}}, dry_coef};
    assign wet_coef_ext = {{(PW-GW){1'b0}}, g_reg};
    assign dry_prod     = dry_ext * dry_coef_ext;
    assign wet_prod     = wet_ext * wet_coef_ext;
    assign mix_sum      = {dry_prod[PW-1], dry_prod} + {wet_prod[PW-1], wet_prod};
    assign mix_out      = mix_sum[RAMP_LOG2 +: DATA_W];
    assign unused_mix_bits = ^{mix_sum[SW-1:RAMP_LOG2+DATA_W], mix_sum[RAMP_LOG2-1:0]};

    always_comb begin
        g_next = g_reg;
        if (en_s_reg && (g_reg != RAMP_G))
            g_next = g_reg + GW'(1);
        else if (!en_s_reg && (g_reg != '0))
            g_next = g_reg - GW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg     <= 1'b0;
            en_s_reg      <= 1'b0;
            state_reg     <= ST_DRY;
            g_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            sync1_reg <= fx_enable;
            en_s_reg  <= sync1_reg;
            if (accept) begin
                out_data_reg  <= mix_out;
                out_valid_reg <= 1'b1;
                g_reg         <= g_next;
                // Transitions look at the gain after this sample's update.
                case (state_reg)
                    ST_DRY:
                        if (en_s_reg) state_reg <= ST_RAMP_UP;
                    ST_RAMP_UP:
                        if (g_next == RAMP_G)
                            state_reg <= ST_WET;
                        else if (!en_s_reg)
                            state_reg <= (g_next == '0) ? ST_DRY : ST_RAMP_DOWN;
                    ST_WET:
                        if (!en_s_reg) state_reg <= ST_RAMP_DOWN;
                    ST_RAMP_DOWN:
                        if (g_next == '0)
                            state_reg <= ST_DRY;
                        else if (en_s_reg)
                            state_reg <= (g_next == RAMP_G) ? ST_WET : ST_RAMP_UP;
                    default:
                        state_reg <= ST_DRY;
                endcase
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_data    = out_data_reg;
    assign xfade_state = state_reg;
    assign gain        = g_reg;

endmodule
